// File: rtl/srambo_pkg.sv
// Shared types and constants for the SRAM arbiter that sits between the Atari
// bus and a fast host port.
package srambo_pkg;

  localparam int ADDR_W      = 19;
  localparam int DATA_W      = 8;
  localparam int HOST_WINDOW = 4;
  localparam int PHASE_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/o2_phase_tracker.sv
// Synchronizes the Atari o2 clock into clk_sys and counts clocks since o2 fell,
// giving the arbiter a measure of how much of the o2-low phase is left.
module o2_phase_tracker
  import srambo_pkg::*;
(
  input  logic               clk,
  input  logic               n_reset,
  input  logic               o2,
  output logic               o2_s,
  output logic               o2_fall,
  output logic [PHASE_W-1:0] phase_cnt
);

  localparam logic [PHASE_W-1:0] PHASE_MAX = '1;

  logic o2_meta;
  logic o2_prev;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      o2_meta   <= 1'b1;
      o2_s      <= 1'b1;
      o2_prev   <= 1'b1;
      phase_cnt <= PHASE_MAX;
    end else begin
      o2_meta <= o2;
      o2_s    <= o2_meta;
      o2_prev <= o2_s;
      if (o2_s)
        phase_cnt <= PHASE_MAX;
      else if (o2_fall)
        phase_cnt <= '0;
      else if (phase_cnt != PHASE_MAX)
        phase_cnt <= phase_cnt + PHASE_W'(1);
    end
  end

  assign o2_fall = o2_prev & ~o2_s;

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM between the Atari bus (combinational pass-through while idle)
// and a host port that slips 3-clk accesses into the early o2-low phase.
//   state  | meaning
//   IDLE   | bus owns the SRAM, host request may be accepted
//   SETUP  | host address/data on the pins, strobes high
//   STROBE | host strobe asserted, read data sampled at exit
//   HOLD   | strobes high, host_ack
module sram_arbiter #(
  parameter int HOST_WINDOW = srambo_pkg::HOST_WINDOW,
  parameter int ADDR_W      = srambo_pkg::ADDR_W
) (
  input  logic                          clk,
  input  logic                          n_reset,
  input  logic                          o2,
  input  logic                          casin,
  input  logic                          bus_n_we,
  input  logic [ADDR_W-1:0]             bus_addr,
  input  logic                          host_req,
  input  logic                          host_we,
  input  logic [ADDR_W-1:0]             host_addr,
  input  logic [srambo_pkg::DATA_W-1:0] host_wdata,
  output logic                          host_ack,
  output logic [srambo_pkg::DATA_W-1:0] host_rdata,
  output logic                          host_overrun,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic                          ram_n_oe,
  output logic                          ram_n_we,
  output logic [srambo_pkg::DATA_W-1:0] ram_dq_o,
  input  logic [srambo_pkg::DATA_W-1:0] ram_dq_i,
  output logic                          ram_dq_oe
);

  import srambo_pkg::*;

  localparam logic [PHASE_W-1:0] WINDOW_LAST = PHASE_W'(HOST_WINDOW);

  state_t               state;
  state_t               state_nxt;
  logic                 o2_s;
  logic                 o2_fall;
  logic [PHASE_W-1:0]   phase_cnt;
  logic                 window_open;
  logic                 start;
  logic                 we_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    wdata_q;

  o2_phase_tracker u_phase (
    .clk       (clk),
    .n_reset   (n_reset),
    .o2        (o2),
    .o2_s      (o2_s),
    .o2_fall   (o2_fall),
    .phase_cnt (phase_cnt)
  );

  // On the fall cycle phase_cnt still shows the stale high-phase value.
  assign window_open = ~o2_s & ~o2_fall & (phase_cnt <= WINDOW_LAST);
  assign start       = (state == ST_IDLE) & host_req & window_open;

  always_ff @(posedge clk) begin
    if (!n_reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = ST_STROBE;
      ST_STROBE: state_nxt = ST_HOLD;
      ST_HOLD:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      host_rdata   <= '0;
      host_overrun <= 1'b0;
    end else begin
      if (start) begin
        we_q    <= host_we;
        addr_q  <= host_addr;
        wdata_q <= host_wdata;
      end
      if (state == ST_STROBE && !we_q)
        host_rdata <= ram_dq_i;
      if (state != ST_IDLE && o2_s)
        host_overrun <= 1'b1;
    end
  end

  always_comb begin
    ram_addr  = bus_addr;
    ram_n_oe  = ~(~casin & o2);
    ram_n_we  = ~(~bus_n_we & ~casin & o2);
    ram_dq_oe = 1'b0;
    host_ack  = 1'b0;
    case (state)
      ST_IDLE: begin
      end
      ST_SETUP: begin
        ram_addr  = addr_q;
        ram_n_oe  = 1'b1;
        ram_n_we  = 1'b1;
        ram_dq_oe = we_q;
      end
      ST_STROBE: begin
        ram_addr  = addr_q;
        ram_n_oe  = we_q;
        ram_n_we  = ~we_q;
        ram_dq_oe = we_q;
      end
      ST_HOLD: begin
        ram_addr  = addr_q;
        ram_n_oe  = 1'b1;
        ram_n_we  = 1'b1;
        ram_dq_oe = we_q;
        host_ack  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign ram_dq_o = wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: scoreboarded host accesses, bus
// pass-through table, o2 window, overrun and reset abort scenarios.
module tb_sram_arbiter;

  localparam int AW = 19;

  logic          clk;
  logic          n_reset;
  logic          o2;
  logic          casin;
  logic          bus_n_we;
  logic [AW-1:0] bus_addr;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [7:0]    host_wdata;
  logic          host_ack;
  logic [7:0]    host_rdata;
  logic          host_overrun;
  logic [AW-1:0] ram_addr;
  logic          ram_n_oe;
  logic          ram_n_we;
  logic [7:0]    ram_dq_o;
  logic [7:0]    ram_dq_i;
  logic          ram_dq_oe;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       we;
    logic [7:0] rdata;
  } exp_t;
  exp_t sb[$];

  sram_arbiter #(.HOST_WINDOW(4), .ADDR_W(AW)) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .o2           (o2),
    .casin        (casin),
    .bus_n_we     (bus_n_we),
    .bus_addr     (bus_addr),
    .host_req     (host_req),
    .host_we      (host_we),
    .host_addr    (host_addr),
    .host_wdata   (host_wdata),
    .host_ack     (host_ack),
    .host_rdata   (host_rdata),
    .host_overrun (host_overrun),
    .ram_addr     (ram_addr),
    .ram_n_oe     (ram_n_oe),
    .ram_n_we     (ram_n_we),
    .ram_dq_o     (ram_dq_o),
    .ram_dq_i     (ram_dq_i),
    .ram_dq_oe    (ram_dq_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: one fixed cell, everything else reads back its low address byte
  assign ram_dq_i = (ram_addr == 19'h00100) ? 8'hC3 : ram_addr[7:0];

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  // Leaves the bench just after the edge where phase_cnt becomes p.
  task automatic to_phase(input int p);
    o2 = 1'b1;
    steps(3);
    o2 = 1'b0;
    steps(3 + p);
  endtask

  task automatic run_access(input logic we, input logic [AW-1:0] addr, input logic [7:0] wd,
                            output int lat, output int we_lows, output int oe_lows,
                            output logic data_ok, output logic setup_ok);
    lat = -1; we_lows = 0; oe_lows = 0; data_ok = 1'b1; setup_ok = 1'b0;
    host_we = we; host_addr = addr; host_wdata = wd; host_req = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == 1)
        setup_ok = (ram_addr === addr) && ram_n_we && ram_n_oe && (ram_dq_oe === we);
      if (!ram_n_we) begin
        we_lows++;
        if (ram_dq_o !== wd || ram_addr !== addr || ram_dq_oe !== 1'b1) data_ok = 1'b0;
      end
      if (!ram_n_oe) begin
        oe_lows++;
        if (ram_addr !== addr || ram_dq_oe !== 1'b0) data_ok = 1'b0;
      end
      if (host_ack) begin
        lat = i;
        host_req = 1'b0;
        break;
      end
    end
    host_req = 1'b0;
  endtask

  task automatic test_reset();
    n_reset = 1'b0; o2 = 1'b1; casin = 1'b1; bus_n_we = 1'b1; bus_addr = 19'h71234;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    steps(3);
    checks++;
    if ({host_ack, host_rdata, host_overrun} !== 10'd0) begin
      failures++;
      $display("FAIL reset_host: ack/rdata/overrun=%b/%h/%b expected 0/00/0", host_ack, host_rdata, host_overrun);
    end
    checks++;
    if ({ram_dq_oe, ram_n_oe, ram_n_we} !== 3'b011) begin
      failures++;
      $display("FAIL reset_strobes: dq_oe/n_oe/n_we=%b%b%b expected 011", ram_dq_oe, ram_n_oe, ram_n_we);
    end
    checks++;
    if (ram_addr !== bus_addr) begin
      failures++;
      $display("FAIL reset_addr: ram_addr=%h expected %h", ram_addr, bus_addr);
    end
    n_reset = 1'b1;
    step();
  endtask

  task automatic test_bus_path();
    logic [2:0] v;
    logic exp_oe, exp_we;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      casin = v[2]; bus_n_we = v[1]; o2 = v[0];
      bus_addr = 19'h40000 + 19'(i * 37);
      #1;
      exp_oe = ~(~casin & o2);
      exp_we = ~(~bus_n_we & ~casin & o2);
      checks++;
      if ({ram_n_oe, ram_n_we, ram_dq_oe, ram_addr} !== {exp_oe, exp_we, 1'b0, bus_addr}) begin
        failures++;
        $display("FAIL bus_path[%0d]: n_oe/n_we/dq_oe/addr=%b/%b/%b/%h expected %b/%b/0/%h",
                 i, ram_n_oe, ram_n_we, ram_dq_oe, ram_addr, exp_oe, exp_we, bus_addr);
      end
    end
    casin = 1'b1; bus_n_we = 1'b1; o2 = 1'b1; bus_addr = 19'h70000;
    steps(3);
  endtask

  task automatic test_write();
    int lat, wl, ol; logic dok, sok; exp_t e;
    to_phase(2);
    sb.push_back('{we: 1'b1, rdata: 8'h00});
    run_access(1'b1, 19'h12345, 8'h5A, lat, wl, ol, dok, sok);
    checks++;
    if (lat != 3) begin
      failures++;
      $display("FAIL write_latency: ack after %0d clk expected 3", lat);
    end
    if (lat > 0) e = sb.pop_front();
    checks++;
    if (wl != 1 || ol != 0 || !dok) begin
      failures++;
      $display("FAIL write_strobe: n_we lows=%0d n_oe lows=%0d data_ok=%b expected 1/0/1", wl, ol, dok);
    end
    checks++;
    if (!sok) begin
      failures++;
      $display("FAIL write_setup: addr=%h dq_oe=%b expected 12345/1 strobes high", ram_addr, ram_dq_oe);
    end
    step();
    checks++;
    if (host_ack !== 1'b0 || ram_dq_oe !== 1'b0) begin
      failures++;
      $display("FAIL write_release: ack=%b dq_oe=%b expected 0/0", host_ack, ram_dq_oe);
    end
  endtask

  task automatic test_read();
    int lat, wl, ol; logic dok, sok; exp_t e;
    to_phase(2);
    sb.push_back('{we: 1'b0, rdata: 8'hC3});
    run_access(1'b0, 19'h00100, 8'h00, lat, wl, ol, dok, sok);
    checks++;
    if (lat != 3) begin
      failures++;
      $display("FAIL read_latency: ack after %0d clk expected 3", lat);
    end
    if (lat > 0) begin
      e = sb.pop_front();
      checks++;
      if (host_rdata !== e.rdata) begin
        failures++;
        $display("FAIL read_data: host_rdata=%h expected %h", host_rdata, e.rdata);
      end
    end
    checks++;
    if (wl != 0 || ol != 1 || !dok || !sok) begin
      failures++;
      $display("FAIL read_strobe: n_we lows=%0d n_oe lows=%0d ok=%b/%b expected 0/1/1/1", wl, ol, dok, sok);
    end
    steps(3);
    checks++;
    if (host_rdata !== 8'hC3) begin
      failures++;
      $display("FAIL read_hold: host_rdata=%h expected c3", host_rdata);
    end
  endtask

  task automatic test_window();
    int early, setup_at, ack_at; exp_t e;
    early = 0; setup_at = -1; ack_at = -1;
    to_phase(5);
    sb.push_back('{we: 1'b0, rdata: 8'h55});
    host_we = 1'b0; host_addr = 19'h00055; host_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (ram_addr !== bus_addr || host_ack) early++;
    end
    o2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ram_addr !== bus_addr || host_ack) early++;
    end
    checks++;
    if (early != 0) begin
      failures++;
      $display("FAIL window_early: %0d cycles out of IDLE expected 0", early);
    end
    o2 = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (setup_at < 0 && ram_addr === host_addr) setup_at = i;
      if (host_ack) begin
        ack_at = i;
        e = sb.pop_front();
        checks++;
        if (host_rdata !== e.rdata) begin
          failures++;
          $display("FAIL window_data: host_rdata=%h expected %h", host_rdata, e.rdata);
        end
        host_req = 1'b0;
        break;
      end
    end
    host_req = 1'b0;
    checks++;
    if (setup_at != 4 || ack_at != 6) begin
      failures++;
      $display("FAIL window_start: setup at %0d ack at %0d expected 4 and 6", setup_at, ack_at);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int acks, first_ack, gap, oe_lows; exp_t e;
    acks = 0; first_ack = -1; gap = -1; oe_lows = 0;
    to_phase(0);
    sb.push_back('{we: 1'b0, rdata: 8'h77});
    sb.push_back('{we: 1'b0, rdata: 8'hA5});
    host_we = 1'b0; host_addr = 19'h00077; host_req = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (!ram_n_oe) oe_lows++;
      if (host_ack) begin
        acks++;
        e = sb.pop_front();
        checks++;
        if (host_rdata !== e.rdata) begin
          failures++;
          $display("FAIL b2b_data%0d: host_rdata=%h expected %h", acks, host_rdata, e.rdata);
        end
        if (acks == 1) begin
          first_ack = i;
          host_addr = 19'h000A5;
        end else begin
          gap = i - first_ack;
          host_req = 1'b0;
          break;
        end
      end
    end
    host_req = 1'b0;
    checks++;
    if (acks != 2 || gap != 4 || oe_lows != 2) begin
      failures++;
      $display("FAIL b2b_timing: acks=%0d gap=%0d oe_lows=%0d expected 2/4/2", acks, gap, oe_lows);
    end
    while (sb.size() > 0) e = sb.pop_front();
    step();
  endtask

  task automatic test_overrun();
    int lat, wl, ol; logic dok, sok; exp_t e;
    to_phase(2);
    checks++;
    if (host_overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_pre: host_overrun=%b expected 0", host_overrun);
    end
    sb.push_back('{we: 1'b1, rdata: 8'h00});
    o2 = 1'b1;
    run_access(1'b1, 19'h0ABCD, 8'h3C, lat, wl, ol, dok, sok);
    if (lat > 0) e = sb.pop_front();
    checks++;
    if (lat != 3 || wl != 1 || !dok) begin
      failures++;
      $display("FAIL overrun_access: lat=%0d n_we lows=%0d data_ok=%b expected 3/1/1", lat, wl, dok);
    end
    steps(2);
    checks++;
    if (host_overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set: host_overrun=%b expected 1", host_overrun);
    end
    o2 = 1'b0; steps(6); o2 = 1'b1; steps(6);
    checks++;
    if (host_overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_sticky: host_overrun=%b expected 1", host_overrun);
    end
  endtask

  task automatic test_reset_abort();
    int stray;
    stray = 0;
    to_phase(2);
    host_we = 1'b1; host_addr = 19'h00F0F; host_wdata = 8'hE7; host_req = 1'b1;
    steps(2);
    checks++;
    if (ram_n_we !== 1'b0 || ram_dq_oe !== 1'b1) begin
      failures++;
      $display("FAIL abort_strobe: n_we=%b dq_oe=%b expected 0/1", ram_n_we, ram_dq_oe);
    end
    n_reset = 1'b0; host_req = 1'b0;
    step();
    checks++;
    if ({ram_dq_oe, host_ack, host_overrun} !== 3'b000 || ram_addr !== bus_addr || host_rdata !== 8'h00) begin
      failures++;
      $display("FAIL abort_reset: dq_oe/ack/overrun=%b%b%b addr=%h rdata=%h expected 000/%h/00",
               ram_dq_oe, host_ack, host_overrun, ram_addr, host_rdata, bus_addr);
    end
    n_reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (host_ack) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL abort_no_ack: %0d stray acks expected 0", stray);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_bus_path();
    test_write();
    test_read();
    test_window();
    test_back_to_back();
    test_overrun();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
